// File: rtl/irq_sched_pkg.sv
// Shared constants for the interrupt scheduler: register word map, FSM states
// and the fixed source indices of the on-chip timers.
package irq_sched_pkg;

  localparam int ID_W = 4;

  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_PEND = 2'd1;
  localparam logic [1:0] IRQ_MODE = 2'd2;
  localparam logic [1:0] IRQ_VEC  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } irq_state_e;

  localparam int SRC_TIMER0 = 0;
  localparam int SRC_TIMER1 = 1;

endpackage

// File: rtl/irq_sched_if.sv
// Bus, source and CP0 handshake signals of the interrupt scheduler.
interface irq_sched_if
  import irq_sched_pkg::*;
#(
  parameter int NUM_SRC = 6
);
  logic [1:0]         ADDR_I;
  logic               WE_I;
  logic [31:0]        DAT_I;
  logic [31:0]        DAT_O;
  logic [NUM_SRC-1:0] SRC_I;
  logic               ACK_I;
  logic               IRQ_O;
  logic [ID_W-1:0]    INT_ID;

  modport master (
    output ADDR_I, WE_I, DAT_I, SRC_I, ACK_I,
    input  DAT_O, IRQ_O, INT_ID
  );

  modport slave (
    input  ADDR_I, WE_I, DAT_I, SRC_I, ACK_I,
    output DAT_O, IRQ_O, INT_ID
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins, index is zero when nothing is set.
module irq_prio_enc
  import irq_sched_pkg::*;
#(
  parameter int NUM_SRC = 6
) (
  input  logic [NUM_SRC-1:0] i_vec,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_idx
);
  always_comb begin
    o_valid = |i_vec;
    o_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = ID_W'(i);
    end
  end
endmodule

// File: rtl/irq_sched.sv
// Interrupt controller: pending/mask/mode registers, edge detection, fixed
// priority arbitration and a request/ack/EOI handshake towards CP0.
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int NUM_SRC = 6
) (
  input logic        clk,
  input logic        reset,
  irq_sched_if.slave bus
);
  logic [NUM_SRC-1:0] r_mask, r_mode, r_pend, r_src_prev;
  irq_state_e         r_state, w_state_next;
  logic [ID_W-1:0]    r_cur_id, w_cur_id_next, w_win_idx, w_int_id;
  logic [NUM_SRC-1:0] w_elig, w_w1c, w_ack_clr, w_cur_onehot, w_rise, w_pend_next;
  logic               w_win_valid, w_eoi, w_ack, w_busy, w_unused;

  assign w_unused     = ^bus.DAT_I;
  assign w_eoi        = bus.WE_I && (bus.ADDR_I == IRQ_VEC);
  assign w_w1c        = (bus.WE_I && (bus.ADDR_I == IRQ_PEND)) ? bus.DAT_I[NUM_SRC-1:0] : '0;
  assign w_ack        = (r_state == S_REQ) && bus.ACK_I;
  assign w_cur_onehot = NUM_SRC'(1) << r_cur_id;
  assign w_ack_clr    = w_ack ? w_cur_onehot : '0;
  assign w_rise       = bus.SRC_I & ~r_src_prev;
  assign w_elig       = r_pend & r_mask;

  // Edge bits: a new rising edge beats both W1C and the ack clear.
  // Level bits simply follow the line.
  assign w_pend_next = (r_mode & ((r_pend & ~w_w1c & ~w_ack_clr) | w_rise))
                     | (~r_mode & bus.SRC_I);

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .i_vec   (w_elig),
    .o_valid (w_win_valid),
    .o_idx   (w_win_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask     <= '0;
      r_mode     <= '0;
      r_pend     <= '0;
      r_src_prev <= '0;
    end else begin
      if (bus.WE_I && (bus.ADDR_I == IRQ_MASK)) r_mask <= bus.DAT_I[NUM_SRC-1:0];
      if (bus.WE_I && (bus.ADDR_I == IRQ_MODE)) r_mode <= bus.DAT_I[NUM_SRC-1:0];
      r_pend     <= w_pend_next;
      r_src_prev <= bus.SRC_I;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cur_id <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cur_id <= w_cur_id_next;
    end
  end

  // The winner is latched only when leaving IDLE, so REQ never pre-empts.
  always_comb begin
    w_state_next  = r_state;
    w_cur_id_next = r_cur_id;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_state_next  = S_REQ;
          w_cur_id_next = w_win_idx;
        end
      end
      S_REQ: begin
        if (w_ack)                           w_state_next = S_SVC;
        else if (~|(w_elig & w_cur_onehot))  w_state_next = S_IDLE;
      end
      S_SVC: begin
        if (w_eoi) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.IRQ_O  = (r_state == S_REQ);
    w_busy     = (r_state != S_IDLE);
    w_int_id   = w_busy ? r_cur_id : '0;
    bus.INT_ID = w_int_id;
  end

  always_comb begin
    bus.DAT_O = '0;
    case (bus.ADDR_I)
      IRQ_MASK: bus.DAT_O = 32'(r_mask);
      IRQ_PEND: bus.DAT_O = 32'(r_pend);
      IRQ_MODE: bus.DAT_O = 32'(r_mode);
      default:  bus.DAT_O = {w_busy, 27'd0, w_int_id};
    endcase
  end
endmodule

// File: tb/tb_irq_sched.sv
// Directed and randomized bench for irq_sched against a cycle-level model.
module tb_irq_sched;
  import irq_sched_pkg::*;

  localparam int NS = 6;
  localparam int unsigned ALL = (32'd1 << NS) - 32'd1;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  irq_sched_if #(.NUM_SRC(NS)) bus ();
  irq_sched #(.NUM_SRC(NS)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // phase: 0 no request, 1 requesting CP0, 2 in service
  typedef struct {
    int unsigned mask, mode, pend, prev;
    int          phase;
    int          cur;
  } mdl_t;

  mdl_t m;

  function automatic int lowest(int unsigned v);
    for (int i = 0; i < NS; i++) if (((v >> i) & 1) != 0) return i;
    return 0;
  endfunction

  function automatic mdl_t step(mdl_t s, int a, bit we, int unsigned d, int unsigned src, bit ack);
    mdl_t        n     = s;
    int unsigned elig  = s.pend & s.mask;
    int unsigned taken = 0;
    int unsigned w1c   = (we && a == 1) ? d : 0;
    case (s.phase)
      0: if (elig != 0) begin n.phase = 1; n.cur = lowest(elig); end
      1: begin
        if (ack) begin n.phase = 2; taken = 32'd1 << s.cur; end
        else if (((elig >> s.cur) & 1) == 0) n.phase = 0;
      end
      default: if (we && a == 3) n.phase = 0;
    endcase
    for (int i = 0; i < NS; i++) begin
      bit now_hi = src[i];
      if (s.mode[i]) begin
        bit rise = now_hi && !s.prev[i];
        bit kept = s.pend[i] && !w1c[i] && !taken[i];
        n.pend[i] = rise || kept;
      end else begin
        n.pend[i] = now_hi;
      end
    end
    if (we && a == 0) n.mask = d & ALL;
    if (we && a == 2) n.mode = d & ALL;
    n.prev = src;
    return n;
  endfunction

  function automatic int unsigned rdexp(mdl_t s, int a);
    case (a)
      0: return s.mask;
      1: return s.pend;
      2: return s.mode;
      default: return (s.phase != 0) ? (32'h8000_0000 | 32'(s.cur)) : 32'd0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    chk(name, act, exp);
    $display("check %-10s value %h", name, act);
  endtask

  task automatic lit_io(string name, int e_irq, int e_id);
    lit({name, ".irq"}, 32'(bus.IRQ_O), 32'(e_irq));
    lit({name, ".id"}, 32'(bus.INT_ID), 32'(e_id));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.WE_I   = 1'b1;
    bus.ADDR_I = a;
    bus.DAT_I  = d;
    cyc();
    bus.WE_I   = 1'b0;
    bus.DAT_I  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.ADDR_I = a;
    #1;
    v = bus.DAT_O;
  endtask

  task automatic ack_pulse();
    bus.ACK_I = 1'b1;
    cyc();
    bus.ACK_I = 1'b0;
  endtask

  // Reference model, updated on the same edges as the DUT.
  initial begin
    m = '{default: 0};
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m = '{default: 0};
      else m = step(m, int'(bus.ADDR_I), bus.WE_I, bus.DAT_I, 32'(bus.SRC_I), bus.ACK_I);
    end
  end

  // Every-cycle comparison, mid-cycle when inputs and outputs are stable.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc.irq", 32'(bus.IRQ_O), (m.phase == 1) ? 32'd1 : 32'd0);
      chk("cyc.id", 32'(bus.INT_ID), (m.phase != 0) ? 32'(m.cur) : 32'd0);
      chk("cyc.dat", bus.DAT_O, rdexp(m, int'(bus.ADDR_I)));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] v;
    bit          got;
    bit          in_rst;

    reset      = 1'b0;
    bus.WE_I   = 1'b0;
    bus.ADDR_I = '0;
    bus.DAT_I  = '0;
    bus.ACK_I  = 1'b0;
    bus.SRC_I  = '1;

    // Reset hold with all sources high
    repeat (2) cyc();
    lit_io("rst", 0, 0);
    for (int a = 0; a < 4; a++) begin
      cyc();
      rd(2'(a), v);
      lit("rst.dat", v, 32'd0);
    end
    reset = 1'b1;
    cyc();
    lit_io("rel", 0, 0);
    bus.SRC_I = '0;
    cyc();

    // Basic edge request on Timer1
    wr(IRQ_MASK, 32'h3F);
    wr(IRQ_MODE, 32'h3F);
    bus.SRC_I = NS'(1) << SRC_TIMER1;
    cyc();
    bus.SRC_I = '0;
    cyc();
    lit_io("edge", 1, SRC_TIMER1);
    ack_pulse();
    lit_io("ack", 0, SRC_TIMER1);
    rd(IRQ_PEND, v); lit("ack.pend", v, 32'd0);
    rd(IRQ_VEC, v);  lit("svc.vec", v, 32'h8000_0001);
    wr(IRQ_VEC, 32'hDEAD_BEEF);
    rd(IRQ_VEC, v);  lit("eoi.vec", v, 32'd0);

    // Priority between two simultaneous edges
    bus.SRC_I = 6'h14;
    cyc();
    bus.SRC_I = '0;
    cyc();
    lit_io("prio1", 1, 2);
    ack_pulse();
    wr(IRQ_VEC, 32'd0);
    lit_io("prio.gap", 0, 0);
    cyc();
    lit_io("prio2", 1, 4);
    ack_pulse();
    wr(IRQ_VEC, 32'd0);

    // Level source withdrawn before ack
    wr(IRQ_MODE, 32'd0);
    bus.SRC_I = 6'h01;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      cyc();
      if (bus.IRQ_O) got = 1'b1;
    end
    lit("lvl.seen", 32'(got), 32'd1);
    bus.SRC_I = '0;
    cyc();
    cyc();
    lit_io("lvl.drop", 0, 0);
    rd(IRQ_VEC, v); lit("lvl.vec", v, 32'd0);

    // Masking and write-one-to-clear
    wr(IRQ_MASK, 32'd0);
    wr(IRQ_MODE, 32'h3F);
    bus.SRC_I = 6'h08;
    cyc();
    bus.SRC_I = '0;
    cyc();
    rd(IRQ_PEND, v); lit("msk.pend", v, 32'h08);
    lit_io("msk", 0, 0);
    wr(IRQ_PEND, 32'h08);
    rd(IRQ_PEND, v); lit("w1c.clr", v, 32'd0);
    bus.SRC_I  = 6'h08;
    bus.WE_I   = 1'b1;
    bus.ADDR_I = IRQ_PEND;
    bus.DAT_I  = 32'h08;
    cyc();
    bus.WE_I  = 1'b0;
    bus.DAT_I = '0;
    bus.SRC_I = '0;
    rd(IRQ_PEND, v); lit("w1c.set", v, 32'h08);
    wr(IRQ_MASK, 32'h08);
    cyc();
    lit_io("msk.on", 1, 3);
    ack_pulse();
    wr(IRQ_VEC, 32'd0);

    // Reset while in service
    wr(IRQ_MASK, 32'h3F);
    bus.SRC_I = 6'h20;
    cyc();
    bus.SRC_I = '0;
    cyc();
    lit_io("r6.req", 1, 5);
    ack_pulse();
    lit_io("r6.svc", 0, 5);
    bus.SRC_I = 6'h01;
    cyc();
    bus.SRC_I = '0;
    rd(IRQ_PEND, v); lit("r6.acc", v, 32'h01);
    lit_io("r6.quiet", 0, 5);
    reset = 1'b0;
    #1;
    lit_io("r6.rst", 0, 0);
    rd(IRQ_PEND, v); lit("r6.pend", v, 32'd0);
    rd(IRQ_VEC, v);  lit("r6.vec", v, 32'd0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    lit_io("r6.rel", 0, 0);
    wr(IRQ_MASK, 32'h3F);
    wr(IRQ_MODE, 32'h3F);
    bus.SRC_I = NS'(1) << SRC_TIMER0;
    cyc();
    bus.SRC_I = '0;
    cyc();
    lit_io("r6.new", 1, SRC_TIMER0);
    ack_pulse();
    wr(IRQ_VEC, 32'd0);

    // Randomized traffic, checked every cycle by the model
    in_rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (in_rst) begin
        reset  = 1'b1;
        in_rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        reset  = 1'b0;
        in_rst = 1'b1;
      end
      bus.WE_I   = ($urandom_range(0, 99) < 12);
      bus.ADDR_I = 2'($urandom_range(0, 3));
      bus.DAT_I  = $urandom;
      bus.SRC_I  = NS'($urandom & $urandom);
      bus.ACK_I  = ($urandom_range(0, 3) == 0);
    end
    reset     = 1'b1;
    bus.WE_I  = 1'b0;
    bus.ACK_I = 1'b0;
    bus.SRC_I = '0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
